// File: rtl/ram_bus_master_if.sv
// Request/response and RAM control signals for ram_bus_master.
// mem_data is bidirectional and is carried as a separate inout port on the master.
interface ram_bus_master_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_addr, mem_cs, mem_we, mem_oe
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_addr, mem_cs, mem_we, mem_oe
    );
endinterface

// File: rtl/ram_bus_master.sv
// Single-request initiator for a synchronous single-port RAM bus; all RAM pins come from flops.
// Optional macro RAM_BUS_MASTER_TURNAROUND_EN inserts a one-cycle idle TURN state after each transaction.
module ram_bus_master #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_bus_master_if.master      bus,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    if (RD_LATENCY == 0) begin : g_bad_latency
        $error("ram_bus_master: RD_LATENCY must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_HOLD  = 3'd3
`ifdef RAM_BUS_MASTER_TURNAROUND_EN
        , TURN   = 3'd4
`endif
    } state_e;

`ifdef RAM_BUS_MASTER_TURNAROUND_EN
    localparam state_e DONE_STATE = TURN;
`else
    localparam state_e DONE_STATE = IDLE;
`endif

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  ready_q, ready_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  drive_q, drive_d;

    // Next state, latched request fields, and pin values decoded from the next state
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = bus.req_we ? WR : RD_ISSUE;
                end
            end
            WR: begin
                rsp_valid_d = 1'b1;
                state_d     = DONE_STATE;
            end
            RD_ISSUE: begin
                cnt_d   = CNT_W'(RD_LATENCY - 1);
                state_d = RD_HOLD;
            end
            RD_HOLD: begin
                if (cnt_q == '0) begin
                    rdata_d     = mem_data;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE_STATE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        cs_d    = (state_d == WR) || (state_d == RD_ISSUE) || (state_d == RD_HOLD);
        we_d    = (state_d == WR);
        oe_d    = (state_d == RD_ISSUE) || (state_d == RD_HOLD);
        drive_d = (state_d == WR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            drive_q     <= drive_d;
        end
    end

    // Data bus is driven only in the write cycle, so it can never overlap mem_oe
    assign mem_data = drive_q ? wdata_q : 'z;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_cs    = cs_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_oe    = oe_q;

endmodule
